encode_arbiter: RTL and testbench
=================================

# encode_arbiter

Sequencer and arbiter that shares a single `encode` 4-bit codifier instance among up to four requesters. It accepts a nibble from one requester at a time through a valid/ack handshake and drives the codifier's A–D inputs. It generates the codifier's `ready` strobe and `reset` and samples S0–S3, then returns the 4-bit code to the granted requester with a one-cycle response pulse. It sits between the requester logic and the `encode` instance, which is clocked only by this block's `enc_ready`.

## Interface
- `NREQ`, default 2: number of requesters, legal 2..4.
- `clk  in  1`: system clock; all state updates on rising edge.
- `reset  in  1`: synchronous, active-high reset.
- `req_valid  in  NREQ`: bit i high means requester i presents a nibble.
- `req_data  in  4*NREQ`: nibble of requester i at `[4i+3:4i]`; bit 3 maps to A, bit 0 to D.
- `req_ack  out  NREQ`: one-cycle pulse on bit g when requester g's nibble is accepted.
- `rsp_valid  out  NREQ`: one-cycle pulse on bit g when the result for g is on `rsp_data`.
- `rsp_data  out  4`: code `{S0,S1,S2,S3}`, held until the next capture.
- `rsp_id  out  2`: index of the last granted requester, held with `rsp_data`.
- `busy  out  1`: high in every state except IDLE.
- `enc_a`, `enc_b`, `enc_c`, `enc_d`  `out  1`: codifier inputs, held stable from SETUP through CAPTURE.
- `enc_ready  out  1`: codifier strobe, high only during STROBE.
- `enc_reset  out  1`: codifier reset, registered copy of `reset`.
- `enc_s0`..`enc_s3`  `in  1`: codifier outputs.

## Operation
- FSM states: IDLE → SETUP → STROBE → CAPTURE → RESPOND → IDLE.
- IDLE:
  - If any `req_valid` bit is high, select grant g (round-robin, see below).
  - Load `req_data[g]` into `enc_a..enc_d`.
  - Pulse `req_ack[g]`, record g, go to SETUP.
  - If no request is pending, stay in IDLE with no outputs changing.
- SETUP: hold enc inputs for one cycle with `enc_ready` low, so data is stable before the strobe edge.
- STROBE: `enc_ready` = 1 for exactly one cycle; the codifier captures on its rising edge.
- CAPTURE: `enc_ready` = 0; at the end of the cycle, sample `{enc_s0,enc_s1,enc_s2,enc_s3}` into `rsp_data` and set `rsp_id` = g.
- RESPOND: `rsp_valid[g]` = 1 for one cycle, then return to IDLE.
- Round-robin grant:
  - Search starts at `last_grant+1` modulo NREQ; the first requester with `req_valid` set wins.
  - `last_grant` updates on every grant.
  - A requester that keeps `req_valid` asserted is re-granted only after all other pending requesters have been served.
- Requester rules:
  - Hold `req_valid` and `req_data` stable until `req_ack` is seen.
  - `req_data` changes after grant have no effect on the transaction in flight.
- Requests are sampled only in IDLE. Requests arriving in other states wait; nothing is dropped while `req_valid` stays high.
- Reset values: state IDLE; `req_ack`, `rsp_valid`, `rsp_data`, `rsp_id`, `busy`, `enc_a..enc_d`, `enc_ready` = 0; `enc_reset` = 1 on the first edge with `reset` high; `last_grant` = NREQ-1, so requester 0 wins first.
- Reset mid-transaction: state goes to IDLE on the next edge and `enc_ready` drops. No `rsp_valid` is issued for the in-flight request; its already-issued ack is not retracted.

## Timing
- Edge k (IDLE, request seen): after k, `req_ack[g]` = 1, state SETUP, enc inputs loaded.
- Edge k+1: `req_ack` = 0, `enc_ready` = 1.
- Edge k+2: `enc_ready` = 0.
- Edge k+3: `rsp_data` valid, `rsp_valid[g]` = 1.
- Edge k+4: `rsp_valid` = 0, IDLE.
- Ack-to-response latency is 3 cycles. Next grant is no earlier than edge k+5, giving 5 cycles per transaction.
- `enc_reset` follows `reset` with one cycle of delay; it deasserts one edge after `reset` falls.

## Configuration
- `ENCODE_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority. The lowest-index requester with `req_valid` high always wins, and `last_grant` still updates for `rsp_id` but does not affect selection.
  - Undefined (default): round-robin as described under Operation.

## Test plan
- Reset, then req 0 with nibble 0000 → `req_ack` = 01 one cycle; 3 cycles later `rsp_valid` = 01, `rsp_data` = 1101, `rsp_id` = 0.
- Req 1 only, nibble 1111 → `rsp_valid` = 10, `rsp_data` = 1010, `rsp_id` = 1; `enc_ready` high exactly one cycle.
- Both requesters held high continuously with nibbles 0101 and 0000 → grants alternate 0,1,0,1; results alternate 1111 and 1101 every 5 cycles.
- Same as previous with `ENCODE_ARB_FIXED_PRIO_EN` defined → only requester 0 is granted while its `req_valid` is held.
- Assert `reset` one cycle in the edge k+1..k+2 window (while `enc_ready` is high) → next cycle IDLE, `enc_ready` = 0, `busy` = 0, `enc_reset` = 1, no `rsp_valid` pulse.
- Change `req_data` of the granted requester during SETUP → `rsp_data` reflects the nibble present at grant.

Source files
------------

// File: rtl/encode_arbiter.sv
// Shares one clocked 4-bit `encode` codifier among NREQ requesters: grant, setup, strobe, capture, respond.
// Define ENCODE_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module encode_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [4*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_ack,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [3:0]          rsp_data,
    output logic [1:0]          rsp_id,
    output logic                busy,
    output logic                enc_a,
    output logic                enc_b,
    output logic                enc_c,
    output logic                enc_d,
    output logic                enc_ready,
    output logic                enc_reset,
    input  logic                enc_s0,
    input  logic                enc_s1,
    input  logic                enc_s2,
    input  logic                enc_s3
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STROBE  = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_RESPOND = 3'd4;

    localparam logic [2:0] NREQ_W3      = 3'(NREQ);
    localparam logic [1:0] LAST_GRANT_R = 2'(NREQ - 1);

    logic [2:0]      state_q,      state_d;
    logic [NREQ-1:0] req_ack_q,    req_ack_d;
    logic [NREQ-1:0] rsp_valid_q,  rsp_valid_d;
    logic [3:0]      rsp_data_q,   rsp_data_d;
    logic [1:0]      rsp_id_q,     rsp_id_d;
    logic [3:0]      enc_nib_q,    enc_nib_d;
    logic            enc_ready_q,  enc_ready_d;
    logic            enc_reset_q,  enc_reset_d;
    logic [1:0]      last_grant_q, last_grant_d;

    logic [3:0]      valid4;
    logic [1:0]      pick;
    logic            found;
    logic [2:0]      cand;

    // Grant selection is purely combinational; it only takes effect in IDLE.
    always_comb begin
        valid4 = 4'(req_valid);
        pick   = last_grant_q;
        found  = 1'b0;
        cand   = 3'd0;
`ifdef ENCODE_ARB_FIXED_PRIO_EN
        for (int off = 0; off < 4; off++) begin
            if (off < NREQ && !found && valid4[2'(off)]) begin
                found = 1'b1;
                pick  = 2'(off);
            end
        end
`else
        for (int off = 1; off <= 4; off++) begin
            if (off <= NREQ) begin
                cand = {1'b0, last_grant_q} + 3'(off);
                if (cand >= NREQ_W3) begin
                    cand = cand - NREQ_W3;
                end
                if (!found && valid4[cand[1:0]]) begin
                    found = 1'b1;
                    pick  = cand[1:0];
                end
            end
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        req_ack_d    = '0;
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        enc_nib_d    = enc_nib_q;
        enc_ready_d  = 1'b0;
        enc_reset_d  = reset;
        last_grant_d = last_grant_q;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    req_ack_d    = NREQ'(1) << pick;
                    enc_nib_d    = req_data[4*pick +: 4];
                    last_grant_d = pick;
                    state_d      = ST_SETUP;
                end
            end
            ST_SETUP: begin
                enc_ready_d = 1'b1;
                state_d     = ST_STROBE;
            end
            ST_STROBE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                rsp_data_d  = {enc_s0, enc_s1, enc_s2, enc_s3};
                rsp_id_d    = last_grant_q;
                rsp_valid_d = NREQ'(1) << last_grant_q;
                state_d     = ST_RESPOND;
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        enc_reset_q <= enc_reset_d;
        if (reset) begin
            state_q      <= ST_IDLE;
            req_ack_q    <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= 4'd0;
            rsp_id_q     <= 2'd0;
            enc_nib_q    <= 4'd0;
            enc_ready_q  <= 1'b0;
            last_grant_q <= LAST_GRANT_R;
        end else begin
            state_q      <= state_d;
            req_ack_q    <= req_ack_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            enc_nib_q    <= enc_nib_d;
            enc_ready_q  <= enc_ready_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign req_ack   = req_ack_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != ST_IDLE);
    assign enc_a     = enc_nib_q[3];
    assign enc_b     = enc_nib_q[2];
    assign enc_c     = enc_nib_q[1];
    assign enc_d     = enc_nib_q[0];
    assign enc_ready = enc_ready_q;
    assign enc_reset = enc_reset_q;

endmodule

// File: tb/tb_encode_arbiter.sv
// Directed bench for encode_arbiter (NREQ=2) with a behavioural stand-in for the encode codifier.
module tb_encode_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_valid;
    logic [7:0] req_data;
    logic [1:0] req_ack;
    logic [1:0] rsp_valid;
    logic [3:0] rsp_data;
    logic [1:0] rsp_id;
    logic       busy;
    logic       enc_a, enc_b, enc_c, enc_d;
    logic       enc_ready, enc_reset;
    logic       enc_s0, enc_s1, enc_s2, enc_s3;
    logic [3:0] s_q;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    encode_arbiter #(.NREQ(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data),
        .req_ack(req_ack), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy),
        .enc_a(enc_a), .enc_b(enc_b), .enc_c(enc_c), .enc_d(enc_d),
        .enc_ready(enc_ready), .enc_reset(enc_reset),
        .enc_s0(enc_s0), .enc_s1(enc_s1), .enc_s2(enc_s2), .enc_s3(enc_s3)
    );

    // Codifier stand-in: known codes for the nibbles the scenarios use.
    function automatic logic [3:0] code_of(input logic [3:0] n);
        case (n)
            4'b0000: code_of = 4'b1101;
            4'b1111: code_of = 4'b1010;
            4'b0101: code_of = 4'b1111;
            default: code_of = n ^ 4'b0110;
        endcase
    endfunction

    always @(posedge enc_ready or posedge enc_reset) begin
        if (enc_reset) s_q <= 4'b0000;
        else           s_q <= code_of({enc_a, enc_b, enc_c, enc_d});
    end
    assign {enc_s0, enc_s1, enc_s2, enc_s3} = s_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 2'b00; req_data = 8'h00;
        tick(); tick();
        n_cmp++; if (req_ack !== 2'b00)   begin n_err++; $display("FAIL rst_ack: got %b exp 00", req_ack); end
        n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL rst_rsp_valid: got %b exp 00", rsp_valid); end
        n_cmp++; if (rsp_data !== 4'h0)   begin n_err++; $display("FAIL rst_rsp_data: got %b exp 0000", rsp_data); end
        n_cmp++; if (rsp_id !== 2'd0)     begin n_err++; $display("FAIL rst_rsp_id: got %0d exp 0", rsp_id); end
        n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rst_busy: got %b exp 0", busy); end
        n_cmp++; if ({enc_a, enc_b, enc_c, enc_d, enc_ready} !== 5'b0) begin
            n_err++; $display("FAIL rst_enc: got %b exp 00000", {enc_a, enc_b, enc_c, enc_d, enc_ready}); end
        n_cmp++; if (enc_reset !== 1'b1)  begin n_err++; $display("FAIL rst_enc_reset: got %b exp 1", enc_reset); end
        reset = 1'b0;
        tick();
        n_cmp++; if (enc_reset !== 1'b0)  begin n_err++; $display("FAIL enc_reset_release: got %b exp 0", enc_reset); end
        tick();
        n_cmp++; if (busy !== 1'b0 || req_ack !== 2'b00) begin
            n_err++; $display("FAIL idle_no_req: busy %b ack %b exp 0 00", busy, req_ack); end
    endtask

    task automatic test_req0_zero();
        req_valid = 2'b01; req_data = 8'h00;
        tick();
        n_cmp++; if (req_ack !== 2'b01) begin n_err++; $display("FAIL r0_ack: got %b exp 01", req_ack); end
        n_cmp++; if (busy !== 1'b1)     begin n_err++; $display("FAIL r0_busy: got %b exp 1", busy); end
        req_valid = 2'b00;
        tick();
        n_cmp++; if (req_ack !== 2'b00) begin n_err++; $display("FAIL r0_ack_pulse: got %b exp 00", req_ack); end
        tick(); tick();
        n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL r0_rsp_valid: got %b exp 01", rsp_valid); end
        n_cmp++; if (rsp_data !== 4'b1101) begin n_err++; $display("FAIL r0_rsp_data: got %b exp 1101", rsp_data); end
        n_cmp++; if (rsp_id !== 2'd0)     begin n_err++; $display("FAIL r0_rsp_id: got %0d exp 0", rsp_id); end
        tick();
        n_cmp++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
            n_err++; $display("FAIL r0_end: rsp_valid %b busy %b exp 00 0", rsp_valid, busy); end
    endtask

    task automatic test_req1_ones();
        req_valid = 2'b10; req_data = 8'hF0;
        tick();
        n_cmp++; if (req_ack !== 2'b10) begin n_err++; $display("FAIL r1_ack: got %b exp 10", req_ack); end
        n_cmp++; if ({enc_a, enc_b, enc_c, enc_d} !== 4'b1111 || enc_ready !== 1'b0) begin
            n_err++; $display("FAIL r1_setup: enc %b ready %b exp 1111 0", {enc_a, enc_b, enc_c, enc_d}, enc_ready); end
        req_valid = 2'b00;
        tick();
        n_cmp++; if (enc_ready !== 1'b1) begin n_err++; $display("FAIL r1_strobe: got %b exp 1", enc_ready); end
        tick();
        n_cmp++; if (enc_ready !== 1'b0) begin n_err++; $display("FAIL r1_strobe_end: got %b exp 0", enc_ready); end
        tick();
        n_cmp++; if (rsp_valid !== 2'b10 || rsp_data !== 4'b1010 || rsp_id !== 2'd1) begin
            n_err++; $display("FAIL r1_rsp: valid %b data %b id %0d exp 10 1010 1", rsp_valid, rsp_data, rsp_id); end
        n_cmp++; if (enc_ready !== 1'b0) begin n_err++; $display("FAIL r1_ready_respond: got %b exp 0", enc_ready); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g;
        // Last grant is 1 here, so round-robin starts at 0.
        req_valid = 2'b11; req_data = 8'h05;
        for (int t = 0; t < 4; t++) begin
`ifdef ENCODE_ARB_FIXED_PRIO_EN
            exp_g = 2'd0;
`else
            exp_g = (t % 2 == 0) ? 2'd0 : 2'd1;
`endif
            tick();
            n_cmp++; if (req_ack !== (2'b01 << exp_g)) begin
                n_err++; $display("FAIL b2b_ack[%0d]: got %b exp %b", t, req_ack, 2'b01 << exp_g); end
            tick(); tick(); tick();
            n_cmp++; if (rsp_valid !== (2'b01 << exp_g) || rsp_id !== exp_g ||
                         rsp_data !== ((exp_g == 2'd0) ? 4'b1111 : 4'b1101)) begin
                n_err++; $display("FAIL b2b_rsp[%0d]: valid %b id %0d data %b exp grant %0d", t, rsp_valid, rsp_id, rsp_data, exp_g); end
            tick();
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid();
        logic saw_rsp;
        saw_rsp = 1'b0;
        req_valid = 2'b01; req_data = 8'h0F;
        tick();
        n_cmp++; if (req_ack !== 2'b01) begin n_err++; $display("FAIL mid_ack: got %b exp 01", req_ack); end
        req_valid = 2'b00;
        tick();
        n_cmp++; if (enc_ready !== 1'b1) begin n_err++; $display("FAIL mid_strobe: got %b exp 1", enc_ready); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0 || enc_ready !== 1'b0 || enc_reset !== 1'b1) begin
            n_err++; $display("FAIL mid_reset: busy %b ready %b enc_reset %b exp 0 0 1", busy, enc_ready, enc_reset); end
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid !== 2'b00) saw_rsp = 1'b1;
            tick();
        end
        n_cmp++; if (saw_rsp !== 1'b0) begin n_err++; $display("FAIL mid_no_rsp: got pulse 1 exp 0"); end
    endtask

    task automatic test_data_change();
        // After reset last grant is 1; only requester 1 asks anyway.
        req_valid = 2'b10; req_data = 8'hF0;
        tick();
        n_cmp++; if (req_ack !== 2'b10) begin n_err++; $display("FAIL chg_ack: got %b exp 10", req_ack); end
        req_valid = 2'b00; req_data = 8'h00;
        tick(); tick(); tick();
        n_cmp++; if (rsp_valid !== 2'b10 || rsp_data !== 4'b1010 || rsp_id !== 2'd1) begin
            n_err++; $display("FAIL chg_rsp: valid %b data %b id %0d exp 10 1010 1", rsp_valid, rsp_data, rsp_id); end
        tick();
    endtask

    initial begin
        test_reset();
        test_req0_zero();
        test_req1_ones();
        test_back_to_back();
        test_reset_mid();
        test_data_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
